// File: rtl/mem_interface.sv
// mem_interface: converts the control unit's level-style memory controls
// (MRE/MWE/IDSel) into a req/ack transaction to a variable-latency unified
// memory, captures fetched instructions (Instr) and loaded data (MDR), stalls
// the control unit until each access completes, and flags misaligned, illegal
// and timed-out accesses with a sticky Err.
//
// Memory handshake: mem_req is raised on the edge that accepts a request and
// stays high, with mem_addr/mem_we/mem_wdata frozen, until the edge that
// samples mem_ack high (the transfer cycle) or the access times out. mem_ack
// is a one-cycle pulse and is only honoured while BUSY; mem_rdata is sampled
// in the same cycle as mem_ack.
module mem_interface #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IDSel,
  input  logic              MRE,
  input  logic              MWE,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] MDR,
  output logic              Stall,
  output logic              Err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Counter exits at TIMEOUT-1, so 8 bits never wrap for TIMEOUT <= 255.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  state_t            state_n;
  logic [7:0]        cnt;
  logic              idsel_q;
  logic              req;
  logic              illegal;
  logic              accept;
  logic              done;
  logic              expire;
  logic [ADDR_W-1:0] addr_sel;

  // Request decode, legality check and next-state selection.
  always_comb begin
    state_n  = state;
    req      = MRE | MWE;
    addr_sel = IDSel ? ALUOut : PC;
    illegal  = (addr_sel[1:0] != 2'b00) | (MRE & MWE) | (MWE & ~IDSel);
    accept   = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            state_n = ERR;
          end else begin
            accept  = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (cnt == TO_LAST) begin
          expire  = 1'b1;
          state_n = ERR;
        end
      end
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Transaction registers, wait counter and holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idsel_q   <= 1'b0;
      cnt       <= 8'd0;
      Instr     <= '0;
      MDR       <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= addr_sel;
        mem_wdata <= WD;
        mem_we    <= MWE;
        idsel_q   <= IDSel;
        mem_req   <= 1'b1;
        cnt       <= 8'd0;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          if (idsel_q) MDR   <= mem_rdata;
          else         Instr <= mem_rdata;
        end
      end
      if (expire) begin
        mem_req <= 1'b0;
      end
      if (state == BUSY && !mem_ack && !expire) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Stall and error flag decoded from state; Stall is held low during reset.
  always_comb begin
    Err       = (state == ERR);
    Stall     = ~reset & (((state == IDLE) & req) |
                          ((state == BUSY) & ~mem_ack) |
                          (state == ERR));
    state_dbg = state;
  end

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed bench for mem_interface. Stimulus pushes the
// expected memory request and the expected holding-register contents into
// queues; a monitor compares them when the DUT raises mem_req, completes a
// transfer, and one cycle later when the captured data must be visible.
module tb_mem_interface;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        IDSel, MRE, MWE;
  logic [31:0] PC, ALUOut, WD;
  logic [31:0] Instr, MDR;
  logic        Stall, Err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .IDSel(IDSel), .MRE(MRE), .MWE(MWE),
    .PC(PC), .ALUOut(ALUOut), .WD(WD), .Instr(Instr), .MDR(MDR),
    .Stall(Stall), .Err(Err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] req_q[$];     // {we, addr, wdata}
  logic [63:0] exp_q[$];     // {Instr, MDR} after each transfer
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_mdr   = '0;
  logic        prev_req  = 1'b0;
  logic        res_pend  = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: request contents at mem_req rise and at the transfer cycle,
  // holding registers one cycle after the transfer.
  always @(negedge clk) begin
    if (res_pend) begin
      res_pend = 1'b0;
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else check("hold_regs", {Instr, MDR}, exp_q.pop_front());
    end
    if (mem_req && !prev_req) begin
      if (req_q.size() == 0) check("unexpected_req", 1, 0);
      else check("req_start", {mem_we, mem_addr, mem_wdata}, req_q[0]);
    end
    if (mem_req && mem_ack) begin
      if (req_q.size() == 0) check("unexpected_xfer", 1, 0);
      else check("req_xfer", {mem_we, mem_addr, mem_wdata}, req_q.pop_front());
      res_pend = 1'b1;
    end
    prev_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; MRE = 1'b0; MWE = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_instr = '0; exp_mdr = '0;
    req_q.delete(); exp_q.delete();
  endtask

  // One access: memory acks in the lat-th cycle with mem_req high.
  task automatic access(input logic idsel, input logic mre, input logic mwe,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int lat, input int exp_stalls);
    int stalls = 0;
    int reqc = 0;
    req_q.push_back({mwe, addr, wd});
    if (!mwe) begin
      if (idsel) exp_mdr = rdata;
      else       exp_instr = rdata;
    end
    exp_q.push_back({exp_instr, exp_mdr});
    IDSel = idsel; MRE = mre; MWE = mwe; WD = wd;
    if (idsel) begin ALUOut = addr; PC = 32'h0000_0DE3; end
    else       begin PC = addr; ALUOut = 32'h0000_0DE3; end
    @(negedge clk); if (Stall) stalls++;
    @(posedge clk); #1;
    for (int k = 1; k <= 50; k++) begin
      if (k == lat) begin mem_ack = 1'b1; mem_rdata = rdata; end
      @(negedge clk);
      if (mem_req) reqc++;
      if (Stall) stalls++;
      @(posedge clk); #1;
      if (k == lat) begin
        mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0; MRE = 1'b0; MWE = 1'b0;
        break;
      end
    end
    check("stall_cycles", stalls, exp_stalls);
    check("req_cycles", reqc, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]  ill_ctl [3];   // {MRE, MWE}
  logic        ill_ids [3];
  logic [31:0] ill_addr[3];

  initial begin
    int reqc;
    int errc;
    ill_ctl[0] = 2'b10; ill_ids[0] = 1'b1; ill_addr[0] = 32'h0000_0102; // misaligned
    ill_ctl[1] = 2'b01; ill_ids[1] = 1'b0; ill_addr[1] = 32'h0000_0040; // store via PC
    ill_ctl[2] = 2'b11; ill_ids[2] = 1'b1; ill_addr[2] = 32'h0000_0100; // read+write

    reset = 1'b1; IDSel = 1'b0; MRE = 1'b1; MWE = 1'b0;
    PC = '0; ALUOut = '0; WD = '0; mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_in_reset", Stall, 0);
    @(posedge clk); #1;
    reset = 1'b0; MRE = 1'b0;
    @(negedge clk);
    check("reset_outputs", {Instr, MDR, Err, Stall, mem_req, mem_we},
          {64'h0, 4'b0000});
    check("reset_addr_data", {mem_addr, mem_wdata}, 64'h0);
    @(posedge clk); #1;

    // fetch, 1-cycle memory
    access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_1111, 32'h8C22_0004, 1, 1);
    // load, 3-cycle memory
    access(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_2222, 32'hDEAD_BEEF, 3, 3);
    // store, 2-cycle memory
    access(1'b1, 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h0F0F_0F0F, 2, 2);
    check("store_no_err", Err, 0);
    // back-to-back fetch accepted in the cycle after the previous ack
    access(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_3333, 32'h2108_FFFC, 1, 1);
    @(posedge clk); #1;

    // ack while IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", {Instr, MDR, mem_req, Stall}, {exp_instr, exp_mdr, 2'b00});
    @(posedge clk); #1;

    // illegal requests: no mem_req, Err/Stall from the next cycle
    for (int t = 0; t < 3; t++) begin
      IDSel = ill_ids[t]; {MRE, MWE} = ill_ctl[t];
      if (ill_ids[t]) ALUOut = ill_addr[t]; else PC = ill_addr[t];
      @(negedge clk);
      check("illegal_first_cycle", {Err, Stall, mem_req}, 3'b010);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        MRE = 1'b0; MWE = 1'b0;
        @(negedge clk);
        check("illegal_err", {Err, Stall, mem_req}, 3'b110);
      end
      do_reset();
    end

    // timeout: mem_req high 15 cycles, Err rises in the next cycle
    req_q.push_back({1'b0, 32'h0000_0300, 32'h0000_4444});
    IDSel = 1'b1; MRE = 1'b1; MWE = 1'b0; ALUOut = 32'h0000_0300; WD = 32'h0000_4444;
    reqc = 0; errc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req) reqc++;
      if (Err && errc < 0) errc = i;
      @(posedge clk); #1;
    end
    check("timeout_req_cycles", reqc, 15);
    check("timeout_err_cycle", errc, 16);
    @(negedge clk);
    check("timeout_err_state", {Err, Stall, mem_req}, 3'b110);
    req_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("stall_forced_low", Stall, 0);
    @(posedge clk); #1;
    reset = 1'b0; MRE = 1'b0;
    exp_instr = '0; exp_mdr = '0;
    @(negedge clk);
    check("post_timeout_reset", {Instr, MDR, Err, Stall, mem_req, mem_we},
          {64'h0, 4'b0000});
    @(posedge clk); #1;

    // load so MDR/Instr are non-zero before the mid-access reset
    access(1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_5555, 32'hA5A5_0001, 1, 1);
    @(posedge clk); #1;

    // reset in the second BUSY cycle of a fetch, late ack after reset
    req_q.push_back({1'b0, 32'h0000_0080, 32'h0000_6666});
    IDSel = 1'b0; MRE = 1'b1; PC = 32'h0000_0080; WD = 32'h0000_6666;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; MRE = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    req_q.delete(); exp_q.delete();
    exp_instr = '0; exp_mdr = '0;
    @(negedge clk);
    check("reset_busy_req", {mem_req, Instr}, 33'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ignored", {Instr, Stall, Err}, 34'h0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'h0000_7777, 32'h0123_4567, 2, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("req_queue_drained", req_q.size(), 0);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_interface.md
# mem_interface

Sequencing block between the multi-cycle control unit and the single unified instruction/data memory. It turns the control unit's level-style memory controls (MRE, MWE, IDSel) into a req/ack transaction to a variable-latency memory. It captures fetched instructions and loaded data into holding registers, and drives a Stall signal that freezes the control unit until each access completes. It also flags misaligned, illegal and timed-out accesses.

## Interface
- ADDR_W, 32, address width (byte addresses, word-aligned accesses only)
- DATA_W, 32, data width
- TIMEOUT, 15, maximum BUSY cycles to wait for mem_ack before error (1..255)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- IDSel  in  1  0 = instruction access (address PC), 1 = data access (address ALUOut)
- MRE  in  1  read request from control unit
- MWE  in  1  write request from control unit
- PC  in  ADDR_W  fetch address
- ALUOut  in  ADDR_W  data address
- WD  in  DATA_W  store data
- Instr  out  DATA_W  instruction holding register
- MDR  out  DATA_W  memory data register (load result)
- Stall  out  1  control unit must hold its state while high
- Err  out  1  sticky error flag
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid in mem_ack cycle

## Operation
- States: IDLE, BUSY, ERR.
- Request = MRE | MWE, sampled only in IDLE.
- The address is PC when IDSel=0 and ALUOut when IDSel=1.
- IDLE, request present, legal: latch address, WD and MWE into mem_addr, mem_wdata and mem_we. Set mem_req. Clear timeout counter. Go to BUSY.
- IDLE, request present, illegal: go to ERR and never assert mem_req. A request is illegal if any of the following holds:
  - address[1:0] != 0
  - MRE & MWE both high
  - MWE with IDSel=0
- BUSY, mem_ack high, read access: capture mem_rdata into Instr if the latched IDSel=0, otherwise into MDR. Drop mem_req and go to IDLE on the same edge.
- BUSY, mem_ack high, write access: drop mem_req and go to IDLE. Instr and MDR are unchanged.
- BUSY, no ack: increment the counter. If the counter reaches TIMEOUT-1 without an ack, go to ERR and drop mem_req.
- ERR: Err=1 and Stall=1. The block stays in ERR until reset, and no further mem_req is issued.
- Stall = (IDLE & request) | (BUSY & ~mem_ack) | ERR. Stall is combinational from state and inputs.
- mem_ack in IDLE or ERR is ignored: no capture, no state change.
- mem_addr, mem_wdata and mem_we are held stable for the entire time mem_req is high.

## Timing
- Reset (synchronous) sets the following on the next edge:
  - state = IDLE
  - mem_req = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - Instr = 0, MDR = 0
  - Err = 0, counter = 0
- Stall is forced to 0 while reset is high.
- Reset mid-BUSY: mem_req is low from the cycle after the reset edge. A late mem_ack is ignored.
- Latency: request seen in cycle N → mem_req high from cycle N+1.
- Ack in cycle M → Stall low in cycle M. Instr or MDR holds the new value from cycle M+1, and mem_req is low in M+1.
- Minimum access (ack in N+1) gives 1 stall cycle (cycle N). Each extra cycle of memory latency adds exactly 1 stall cycle.
- Back-to-back accesses: a request in cycle M+1 is accepted at once, with 1 idle cycle on mem_req between transactions.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles. Err rises in the following cycle.
- Counter width is 8 bits and does not wrap, because the counter exits at TIMEOUT-1.

## Test plan
- Fetch: IDSel=0, MRE=1, PC=0x0000_0040, memory acks 1 cycle later with 0x8C22_0004 → mem_addr=0x40, mem_we=0, Stall high for 1 cycle, Instr=0x8C22_0004, MDR unchanged.
- Load with 3-cycle latency: IDSel=1, MRE=1, ALUOut=0x100, rdata 0xDEAD_BEEF → Stall high for 3 cycles, mem_req high for 3 cycles, MDR=0xDEAD_BEEF, Instr unchanged.
- Store: IDSel=1, MWE=1, ALUOut=0x204, WD=0x1234_5678, ack after 2 cycles → mem_we=1, mem_wdata=0x1234_5678 held while mem_req is high, no register change, Err=0.
- Errors:
  - Misaligned access (ALUOut=0x102, MRE=1) → mem_req never asserted, Err=1 and Stall=1 from the next cycle.
  - MWE with IDSel=0 → Err.
- Timeout (TIMEOUT=15): read with no ack → mem_req high for 15 cycles, then Err=1 and mem_req=0. Err persists until reset, then all outputs return to 0.
- Reset during BUSY (cycle 2 of a fetch), ack arriving 1 cycle after reset → mem_req=0 and Instr=0 after the reset edge, the late ack is ignored, and a following fetch completes normally.
